// File: rtl/mx_conv_seq.sv
// Sequencer and flow-control shell around the bf16-to-MX block converter:
// gathers input beats into blocks, launches them against output-buffer credit, buffers results.
module mx_conv_seq #(
    parameter int unsigned K          = 32,
    parameter int unsigned LANES      = 8,
    parameter int unsigned EXP_WIDTH  = 3,
    parameter int unsigned MAN_WIDTH  = 2,
    parameter int unsigned CONV_LAT   = 5,
    parameter int unsigned OBUF_DEPTH = 4,
    localparam int unsigned BIT_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH,
    localparam int unsigned INF_W     = $clog2(CONV_LAT + 1) + 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    output logic                   o_in_ready,
    input  logic [16*LANES-1:0]    i_data,
    input  logic                   i_last,
    output logic [16*K-1:0]        o_conv_vec,
    input  logic [BIT_WIDTH*K-1:0] i_conv_mx_vec,
    input  logic [7:0]             i_conv_mx_exp,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [BIT_WIDTH*K-1:0] o_mx_vec,
    output logic [7:0]             o_mx_exp,
    output logic [INF_W-1:0]       o_inflight,
    output logic                   o_busy
);

    localparam int unsigned BEATS  = K / LANES;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned CNT_W  = $clog2(OBUF_DEPTH + 1);
    localparam int unsigned VEC_W  = BIT_WIDTH * K;

    typedef enum logic [0:0] {FILL, LAUNCH} state_e;

    typedef struct packed {
        logic [7:0]       mx_exp;
        logic [VEC_W-1:0] mx_vec;
    } entry_t;

    logic [1:0]          rst_sync_q;
    logic                rst_n_s;

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [16*K-1:0]     asm_q, asm_d;
    logic [CONV_LAT-1:0] tok_q, tok_d;
    logic [INF_W-1:0]    inflight_q, inflight_d;
    entry_t              fifo_q [OBUF_DEPTH];
    entry_t              fifo_d [OBUF_DEPTH];
    logic [CNT_W-1:0]    fcnt_q, fcnt_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;

    logic                accept_c, final_c, credit_c, launch_c, push_c, pop_c;
    logic [CNT_W-1:0]    wr_idx;

    // Async assert, synchronous release of the internal reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_s = rst_sync_q[1];

    assign accept_c = i_valid && in_ready_q;
    assign final_c  = accept_c && ((beat_cnt_q == BEAT_W'(BEATS - 1)) || i_last);
    assign credit_c = (32'(inflight_q) + 32'(fcnt_q)) < OBUF_DEPTH;
    assign launch_c = (state_q == LAUNCH) && credit_c;
    assign push_c   = tok_q[CONV_LAT-1];
    assign pop_c    = out_valid_q && i_out_ready;
    assign wr_idx   = pop_c ? (fcnt_q - CNT_W'(1)) : fcnt_q;

    // Block assembly, launch sequencing and token line
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        asm_d      = asm_q;
        unique case (state_q)
            FILL: begin
                if (accept_c) begin
                    for (int unsigned b = 0; b < BEATS; b++) begin
                        for (int unsigned l = 0; l < LANES; l++) begin
                            if (BEAT_W'(b) == beat_cnt_q)
                                asm_d[16*(b*LANES+l) +: 16] = i_data[16*l +: 16];
                            else if (i_last && (BEAT_W'(b) > beat_cnt_q))
                                asm_d[16*(b*LANES+l) +: 16] = 16'h0000;
                        end
                    end
                    if (final_c) begin
                        state_d    = LAUNCH;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    end
                end
            end
            LAUNCH: begin
                if (launch_c) state_d = FILL;
            end
            default: state_d = FILL;
        endcase

        tok_d      = tok_q << 1;
        tok_d[0]   = launch_c;
        inflight_d = inflight_q + INF_W'(launch_c) - INF_W'(push_c);
    end

    // Shift FIFO: entry 0 is the head, slots at or above the count always hold zero
    always_comb begin
        fifo_d = fifo_q;
        if (pop_c) begin
            for (int unsigned i = 0; i + 1 < OBUF_DEPTH; i++) fifo_d[i] = fifo_q[i+1];
            fifo_d[OBUF_DEPTH-1] = '0;
        end
        if (push_c) begin
            for (int unsigned i = 0; i < OBUF_DEPTH; i++) begin
                if (CNT_W'(i) == wr_idx) begin
                    fifo_d[i].mx_exp = i_conv_mx_exp;
                    fifo_d[i].mx_vec = i_conv_mx_vec;
                end
            end
        end
        fcnt_d      = fcnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
        out_valid_d = (fcnt_d != '0);
        in_ready_d  = (state_d == FILL);
        busy_d      = (state_d != FILL) || (beat_cnt_d != '0) || (inflight_d != '0) || (fcnt_d != '0);
    end

    always_ff @(posedge i_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q     <= FILL;
            beat_cnt_q  <= '0;
            asm_q       <= '0;
            tok_q       <= '0;
            inflight_q  <= '0;
            fifo_q      <= '{default: '0};
            fcnt_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            asm_q       <= asm_d;
            tok_q       <= tok_d;
            inflight_q  <= inflight_d;
            fifo_q      <= fifo_d;
            fcnt_q      <= fcnt_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign o_in_ready  = in_ready_q;
    assign o_conv_vec  = asm_q;
    assign o_out_valid = out_valid_q;
    assign o_mx_vec    = fifo_q[0].mx_vec;
    assign o_mx_exp    = fifo_q[0].mx_exp;
    assign o_inflight  = inflight_q;
    assign o_busy      = busy_q;

endmodule
